// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM encoding and architectural constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory, and hands each fetched instruction plus its PC to decode.
// Redirects (taken branch / JAL) replace the PC and squash any in-flight fetch.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imm_ext,
    output logic        misalign_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         misalign_q, misalign_d;

    // Redirect target wraps modulo 2^32; the low bits are dropped to keep fetch word-aligned.
    logic [31:0]  target_raw;
    logic [31:0]  target;
    assign target_raw = redirect_pc + imm_ext;
    assign target     = {target_raw[31:2], 2'b00};

    // Request side is decoded straight from state and PC so the address is stable until accepted.
    assign imem_req_valid = (state_q == REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign misalign_err   = misalign_q;

    // Next-state logic: redirect has priority over every handshake in the same cycle.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        misalign_d    = redirect_valid && (target_raw[1:0] != 2'b00);

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) pc_d = target;
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_d = target;
                    // An accepted request now fetches the wrong address; its response must be eaten.
                    if (imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = target;
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d       = imem_rsp_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                        state_d       = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_d          = target;
                    state_d       = REQ;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset to the architectural reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            misalign_q    <= misalign_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core. Holds the PC, requests 32-bit words from instruction memory over a valid/ready interface, and presents each fetched instruction with its PC to the decode stage. The decoder and immediate extender consume this stage's output. Taken branches and jumps redirect it using the extended immediate that comes back from the extender.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.

**Ports**
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request is valid.
- `imem_addr` out 32: word-aligned fetch address.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: response data is valid (single-cycle pulse).
- `imem_rsp_data` in 32: fetched instruction word.
- `instr_valid` out 1: `instr` and `instr_pc` are valid.
- `instr` out 32: instruction to the decoder and immediate extender (bits [31:7] feed the extender).
- `instr_pc` out 32: PC of `instr`.
- `instr_ready` in 1: decode consumes the instruction.
- `redirect_valid` in 1: taken branch or JAL this cycle.
- `redirect_pc` in 32: PC of the redirecting instruction.
- `imm_ext` in 32: sign-extended immediate from the immediate extender.
- `misalign_err` out 1: one-cycle pulse when a redirect target is not word-aligned.

## Operation

- **States:** IDLE, REQ, WAIT, HOLD. Reset enters IDLE. IDLE moves to REQ unconditionally on the next cycle.
- **REQ:**
  - `imem_req_valid=1` and `imem_addr=pc`.
  - On `imem_req_ready`, go to WAIT.
  - Request and address stay stable until accepted.
- **WAIT:**
  - On `imem_rsp_valid`, capture `imem_rsp_data` into `instr` and `pc` into `instr_pc`, set `instr_valid`, compute `pc <= pc + 4`, and go to HOLD.
  - Exactly one request is outstanding at any time.
- **HOLD:**
  - `instr_valid=1`, with `instr` and `instr_pc` stable until `instr_ready`.
  - On the handshake, clear `instr_valid` and go to REQ.
- **Redirect target:** `target = redirect_pc + imm_ext`, a 32-bit add with modulo 2^32 wrap.
  - Bits [1:0] are forced to 0.
  - If `target[1:0]` was not 0, pulse `misalign_err` for one cycle.
- **Redirect priority:** redirect overrides all other events in the same cycle.
  - In REQ without `imem_req_ready`: `pc <= target` and stay in REQ. Changing the address here is allowed because the request was not accepted.
  - In REQ with `imem_req_ready`: the accepted request is stale. Set `drop=1`, `pc <= target`, go to WAIT.
  - In WAIT: set `drop=1` and `pc <= target`. If a response arrives in the same cycle, discard it, clear `drop`, and go to REQ.
  - In HOLD: clear `instr_valid`, `pc <= target`, go to REQ. A simultaneous `instr_ready` is ignored.
  - In IDLE: `pc <= target`.
- **Stale responses:** in WAIT with `drop=1`, a response is discarded and its data never reaches `instr`. Then clear `drop` and go to REQ.
- **PC increment:** `pc + 4` wraps from `32'hFFFF_FFFC` to `32'h0000_0000`.

## Timing

- **Reset values (asynchronous):**
  - state=IDLE, `pc=RESET_PC`, `drop=0`.
  - `imem_req_valid=0`, `imem_addr=RESET_PC`.
  - `instr_valid=0`, `instr=32'h0000_0013` (NOP), `instr_pc=RESET_PC`.
  - `misalign_err=0`.
- **First request:** `imem_req_valid` rises in the second cycle after `rst_n` deasserts (IDLE lasts one cycle).
- **Latency:** `imem_rsp_valid` in cycle t gives `instr_valid=1` in cycle t+1.
- **Throughput:** with zero-wait memory, one instruction every 3 cycles (REQ → WAIT → HOLD).
- **Registered outputs:** all outputs are registered except `imem_addr` and `imem_req_valid`, which decode from the state and `pc` registers.
- **Reset mid-operation:** returns immediately to the reset values. A response arriving after reset deassertion while in IDLE or REQ is ignored.

## Structure

- **Shared package `riscv_pkg`:**
  - enum `fetch_state_t` {IDLE, REQ, WAIT, HOLD}
  - constant `NOP_INSTR = 32'h0000_0013`
  - constant `DEFAULT_RESET_PC`
- **No sub-module.** The target adder is a single expression inside `fetch_unit`.

## Test plan

1. **Reset:** `rst_n` low, then high.
   - Outputs equal the reset values: `instr=0x00000013`.
   - Cycle 2 after release: `imem_req_valid=1`, `imem_addr=0x0`.
2. **Straight-line fetch:** zero-wait memory returns `0x00500093` and `0x00108113`, with `instr_ready=1`.
   - `instr_pc` sequence is 0x0, then 0x4.
   - Each instruction appears one cycle after `imem_rsp_valid`.
3. **Backpressure:** `instr_ready=0` for 5 cycles while in HOLD.
   - `instr` is stable and `imem_req_valid=0` throughout.
   - Releasing `instr_ready` gives REQ with `imem_addr=0x8` on the next cycle.
4. **Redirect in WAIT:** `redirect_pc=0x10`, `imm_ext=0xFFFF_FFF8`.
   - The in-flight response is dropped with `instr_valid` staying 0.
   - The next request has `imem_addr=0x8`.
5. **Redirect coinciding with a response:**
   - Same cycle as the response: the response is discarded and the next `imem_addr` is the target.
   - Odd target 0x22: `imem_addr=0x20` and `misalign_err` pulses once.
6. **Wrap-around:** `RESET_PC=0xFFFF_FFFC`; after one fetch, the next `imem_addr=0x0`.
